// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and memory results into one register-file write port,
// committing one write per cycle in acceptance order, with pending-write lookups for decode.
module writeback_arbiter #(
  parameter int D  = 5,
  parameter int W  = 32,
  parameter int QD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [D-1:0]           alu_addr,
  input  logic [W-1:0]           alu_data,
  input  logic                   mem_valid,
  input  logic [D-1:0]           mem_addr,
  input  logic [W-1:0]           mem_data,
  output logic                   wb_ready,
  output logic                   rf_write_enable,
  output logic [D-1:0]           rf_address3,
  output logic [W-1:0]           rf_write_data,
  input  logic [D-1:0]           q_addr1,
  input  logic [D-1:0]           q_addr2,
  output logic                   q_hit1,
  output logic                   q_hit2,
  output logic [$clog2(QD):0]    occupancy
);

  localparam int PW = $clog2(QD);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] READY_LIMIT = OW'(QD - 2);

  logic [D-1:0]  addr_q [QD];
  logic [W-1:0]  data_q [QD];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic          acc_mem;
  logic          acc_alu;
  logic          pop;
  logic          slot0_v;
  logic          slot1_v;
  logic [D-1:0]  slot0_a;
  logic [W-1:0]  slot0_d;
  logic          bypass_v;
  logic          enq0_v;
  logic          enq1_v;
  logic [D-1:0]  enq0_a;
  logic [W-1:0]  enq0_d;
  logic [1:0]    enq_count;

  assign wb_ready = (occupancy <= READY_LIMIT);
  assign acc_mem  = mem_valid && wb_ready && (mem_addr != '0);
  assign acc_alu  = alu_valid && wb_ready && (alu_addr != '0);
  assign pop      = (occupancy != '0);

  // Accepted inputs compacted in logical order (mem before alu); the oldest
  // bypasses to the outputs only when the queue has nothing older to commit.
  always_comb begin
    slot0_v   = acc_mem || acc_alu;
    slot0_a   = acc_mem ? mem_addr : alu_addr;
    slot0_d   = acc_mem ? mem_data : alu_data;
    slot1_v   = acc_mem && acc_alu;
    bypass_v  = 1'b0;
    enq0_v    = 1'b0;
    enq0_a    = slot0_a;
    enq0_d    = slot0_d;
    enq1_v    = 1'b0;
    if (pop) begin
      enq0_v = slot0_v;
      enq1_v = slot1_v;
    end else begin
      bypass_v = slot0_v;
      enq0_v   = slot1_v;
      enq0_a   = alu_addr;
      enq0_d   = alu_data;
    end
    enq_count = {1'b0, enq0_v} + {1'b0, enq1_v};
  end

  always_ff @(posedge clk) begin
    if (enq0_v) begin
      addr_q[wr_ptr] <= enq0_a;
      data_q[wr_ptr] <= enq0_d;
    end
    if (enq1_v) begin
      addr_q[wr_ptr + PW'(1)] <= alu_addr;
      data_q[wr_ptr + PW'(1)] <= alu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      occupancy       <= '0;
      rf_write_enable <= 1'b0;
      rf_address3     <= '0;
      rf_write_data   <= '0;
    end else begin
      rd_ptr    <= rd_ptr + PW'(pop);
      wr_ptr    <= wr_ptr + PW'(enq_count);
      occupancy <= occupancy + OW'(enq_count) - OW'(pop);
      if (pop) begin
        rf_write_enable <= 1'b1;
        rf_address3     <= addr_q[rd_ptr];
        rf_write_data   <= data_q[rd_ptr];
      end else if (bypass_v) begin
        rf_write_enable <= 1'b1;
        rf_address3     <= slot0_a;
        rf_write_data   <= slot0_d;
      end else begin
        rf_write_enable <= 1'b0;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below occupancy.
  always_comb begin
    logic          hit1;
    logic          hit2;
    logic [PW-1:0] offset;
    hit1   = rf_write_enable && (rf_address3 == q_addr1);
    hit2   = rf_write_enable && (rf_address3 == q_addr2);
    offset = '0;
    for (int i = 0; i < QD; i++) begin
      offset = PW'(i) - rd_ptr;
      if ({1'b0, offset} < occupancy) begin
        if (addr_q[i] == q_addr1) hit1 = 1'b1;
        if (addr_q[i] == q_addr2) hit2 = 1'b1;
      end
    end
    q_hit1 = hit1 && (q_addr1 != '0);
    q_hit2 = hit2 && (q_addr2 != '0);
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter, checked against a queue-based
// model of the logical commit order.
module tb_writeback_arbiter;

  localparam int D  = 5;
  localparam int W  = 32;
  localparam int QD = 4;

  typedef struct packed {
    logic [D-1:0] a;
    logic [W-1:0] d;
  } entry_t;

  logic                 clk;
  logic                 rst;
  logic                 alu_valid;
  logic [D-1:0]         alu_addr;
  logic [W-1:0]         alu_data;
  logic                 mem_valid;
  logic [D-1:0]         mem_addr;
  logic [W-1:0]         mem_data;
  logic                 wb_ready;
  logic                 rf_write_enable;
  logic [D-1:0]         rf_address3;
  logic [W-1:0]         rf_write_data;
  logic [D-1:0]         q_addr1;
  logic [D-1:0]         q_addr2;
  logic                 q_hit1;
  logic                 q_hit2;
  logic [$clog2(QD):0]  occupancy;

  int compared;
  int mismatched;

  // Model: every accepted non-zero write not yet committed, oldest first.
  entry_t       pq[$];
  logic         m_we;
  logic [D-1:0] m_addr;
  logic [W-1:0] m_data;
  logic         m_accepted;

  writeback_arbiter #(.D(D), .W(W), .QD(QD)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_ready(wb_ready),
    .rf_write_enable(rf_write_enable), .rf_address3(rf_address3), .rf_write_data(rf_write_data),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic mv, input logic [D-1:0] ma, input logic [W-1:0] md,
                               input logic av, input logic [D-1:0] aa, input logic [W-1:0] ad);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
  endtask

  function automatic logic model_hit(input logic [D-1:0] a);
    if (a == '0) return 1'b0;
    if (m_we && m_addr == a) return 1'b1;
    foreach (pq[i]) if (pq[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [D-1:0] pick_lookup();
    if (pq.size() != 0 && $urandom_range(0, 1) == 1)
      return pq[$urandom_range(0, pq.size() - 1)].a;
    return D'($urandom_range(0, (1 << D) - 1));
  endfunction

  task automatic model_reset();
    pq.delete();
    m_we = 1'b0; m_addr = '0; m_data = '0;
    m_accepted = 1'b1;
  endtask

  // One clock: model the edge, check registered outputs, then lookups and ready.
  task automatic step(input logic [D-1:0] qa1, input logic [D-1:0] qa2);
    entry_t e;
    @(posedge clk);
    m_accepted = ((QD - pq.size()) >= 2);
    if (m_accepted) begin
      if (mem_valid && mem_addr != '0) begin e.a = mem_addr; e.d = mem_data; pq.push_back(e); end
      if (alu_valid && alu_addr != '0) begin e.a = alu_addr; e.d = alu_data; pq.push_back(e); end
    end
    if (pq.size() != 0) begin
      e = pq.pop_front();
      m_we = 1'b1; m_addr = e.a; m_data = e.d;
    end else begin
      m_we = 1'b0;
    end
    #1;
    checkOutput("rf_write_enable", rf_write_enable, m_we);
    if (m_we) begin
      checkOutput("rf_address3", rf_address3, m_addr);
      checkOutput("rf_write_data", rf_write_data, m_data);
    end
    checkOutput("occupancy", occupancy, pq.size());
    @(negedge clk);
    q_addr1 = qa1; q_addr2 = qa2;
    #1;
    checkOutput("q_hit1", q_hit1, model_hit(qa1));
    checkOutput("q_hit2", q_hit2, model_hit(qa2));
    checkOutput("wb_ready", wb_ready, (QD - pq.size()) >= 2);
  endtask

  task automatic idle(input int n);
    applyStimulus(0, '0, '0, 0, '0, '0);
    for (int i = 0; i < n; i++) step(pick_lookup(), pick_lookup());
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    q_addr1 = '0; q_addr2 = '0;
    applyStimulus(0, '0, '0, 0, '0, '0);
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_we", rf_write_enable, 0);
    checkOutput("reset_addr", rf_address3, 0);
    checkOutput("reset_data", rf_write_data, 0);
    checkOutput("reset_occupancy", occupancy, 0);
    rst = 1'b0;
    #1;
    checkOutput("reset_ready", wb_ready, 1);

    $display("[TB] single ALU write");
    applyStimulus(0, '0, '0, 1, 5'd5, 32'h1234);
    step(5'd5, 5'd0);
    checkOutput("t1_addr", rf_address3, 5);
    checkOutput("t1_data", rf_write_data, 32'h1234);
    idle(2);

    $display("[TB] same-cycle pair");
    applyStimulus(1, 5'd7, 32'hAAAA, 1, 5'd7, 32'hBBBB);
    step(5'd7, 5'd3);
    checkOutput("t2_first_data", rf_write_data, 32'hAAAA);
    checkOutput("t2_hit", q_hit1, 1);
    idle(1);
    checkOutput("t2_second_data", rf_write_data, 32'hBBBB);
    idle(2);

    $display("[TB] backpressure");
    for (int i = 0; i < 14; i++) begin
      if (m_accepted)
        applyStimulus(1, D'(2 * (i % 15) + 1), 32'h100 + i, 1, D'(2 * (i % 15) + 2), 32'h200 + i);
      step(pick_lookup(), pick_lookup());
    end
    idle(6);

    $display("[TB] zero register");
    applyStimulus(0, '0, '0, 1, 5'd0, 32'hFFFF);
    step(5'd0, 5'd0);
    checkOutput("t4_we", rf_write_enable, 0);
    checkOutput("t4_hit", q_hit1, 0);
    idle(2);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, D'(10 + i), 32'h300 + i, 1, D'(20 + i), 32'h400 + i);
      step(pick_lookup(), pick_lookup());
    end
    applyStimulus(0, '0, '0, 0, '0, '0);
    checkOutput("t5_queued", occupancy, 3);
    #1 rst = 1'b1;
    #1;
    model_reset();
    checkOutput("t5_we", rf_write_enable, 0);
    checkOutput("t5_addr", rf_address3, 0);
    checkOutput("t5_data", rf_write_data, 0);
    checkOutput("t5_occupancy", occupancy, 0);
    #1 rst = 1'b0;
    idle(6);

    $display("[TB] pointer wrap");
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, '0, '0, 1, D'(i), W'(i * 32'h11));
      step(D'(i), pick_lookup());
      checkOutput("t6_data", rf_write_data, i * 32'h11);
      idle(1);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      int rate;
      rate = (i < 200) ? 80 : 40;
      if (!mem_valid || m_accepted) begin
        mem_valid = ($urandom_range(0, 99) < rate);
        mem_addr  = D'($urandom_range(0, (1 << D) - 1));
        mem_data  = $urandom;
      end
      if (!alu_valid || m_accepted) begin
        alu_valid = ($urandom_range(0, 99) < rate);
        alu_addr  = D'($urandom_range(0, (1 << D) - 1));
        alu_data  = $urandom;
      end
      step(pick_lookup(), pick_lookup());
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
